// File: rtl/mem_arb_pkg.sv
// Shared types, default widths and packed-vector helpers for the N-port memory arbiter.
package mem_arb_pkg;

  typedef enum logic {PORT_A = 1'b0, PORT_B = 1'b1} port_t;

  localparam int unsigned DefDataWidth = 32;
  localparam int unsigned DefAddrWidth = 32;
  localparam int unsigned DefMemAw     = 8;
  localparam int unsigned MaxVecW      = 4096;

  // Pull element idx of the given width (max 64 bits) out of a packed array.
  function automatic logic [63:0] get_slice(logic [MaxVecW-1:0] vec, int unsigned idx,
                                            int unsigned width);
    logic [MaxVecW-1:0] shifted;
    shifted = vec >> (idx * width);
    return shifted[63:0] & ((64'd1 << width) - 64'd1);
  endfunction

endpackage

// File: rtl/mem_arb_rank.sv
// Combinational top-two picker: urgent requesters rank first, lower index wins within a class.
module mem_arb_rank #(
  parameter int unsigned NUM_REQ = 3,
  parameter int unsigned IDX_W   = 2
) (
  input  logic [NUM_REQ-1:0] active,
  input  logic [NUM_REQ-1:0] urgent,
  output logic [IDX_W-1:0]   first_idx,
  output logic               first_vld,
  output logic [IDX_W-1:0]   second_idx,
  output logic               second_vld
);

  always_comb begin
    first_vld  = 1'b0;
    first_idx  = '0;
    second_vld = 1'b0;
    second_idx = '0;
    // Pass 0 scans urgent requesters, pass 1 the rest.
    for (int p = 0; p < 2; p++) begin
      for (int i = 0; i < NUM_REQ; i++) begin
        if (active[i] && ((p == 0) ? urgent[i] : !urgent[i])) begin
          if (!first_vld) begin
            first_vld = 1'b1;
            first_idx = IDX_W'(i);
          end else if (!second_vld) begin
            second_vld = 1'b1;
            second_idx = IDX_W'(i);
          end
        end
      end
    end
  end

endmodule

// File: rtl/memory_map.sv
// Dual-port SRAM with registered read data on both ports; only the low MEM_AW address bits decode.
module memory_map #(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned ADDR_WIDTH = 32,
  parameter int unsigned MEM_AW     = 8
) (
  input  logic                  clk,
  input  logic                  we_a,
  input  logic [ADDR_WIDTH-1:0] addr_a,
  input  logic [DATA_WIDTH-1:0] wdata_a,
  output logic [DATA_WIDTH-1:0] q_a,
  input  logic                  we_b,
  input  logic [ADDR_WIDTH-1:0] addr_b,
  input  logic [DATA_WIDTH-1:0] wdata_b,
  output logic [DATA_WIDTH-1:0] q_b
);

  logic [DATA_WIDTH-1:0] mem [2**MEM_AW];

  always_ff @(posedge clk) begin
    if (we_a) mem[addr_a[MEM_AW-1:0]] <= wdata_a;
    if (we_b) mem[addr_b[MEM_AW-1:0]] <= wdata_b;
    q_a <= mem[addr_a[MEM_AW-1:0]];
    q_b <= mem[addr_b[MEM_AW-1:0]];
  end

  logic unused_addr_hi;
  assign unused_addr_hi = ^{addr_a[ADDR_WIDTH-1:MEM_AW], addr_b[ADDR_WIDTH-1:MEM_AW]};

endmodule

// File: rtl/mem_arbiter_nport.sv
// N-requester arbiter granting up to two accesses per cycle onto the dual-port memory_map,
// with starvation aging, same-address write hazard blocking and one response per grant.
module mem_arbiter_nport
  import mem_arb_pkg::*;
#(
  parameter int unsigned DATA_WIDTH   = DefDataWidth,
  parameter int unsigned ADDR_WIDTH   = DefAddrWidth,
  parameter int unsigned NUM_REQ      = 3,
  parameter int unsigned STARVE_LIMIT = 4
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic [NUM_REQ-1:0]            req_en,
  input  logic [NUM_REQ-1:0]            req_we,
  input  logic [NUM_REQ*ADDR_WIDTH-1:0] req_addr,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] req_wdata,
  output logic [NUM_REQ-1:0]            req_ready,
  output logic [NUM_REQ-1:0]            rsp_valid,
  output logic [NUM_REQ*DATA_WIDTH-1:0] rsp_rdata
);

  localparam int unsigned IdxW = $clog2(NUM_REQ);
  localparam int unsigned CntW = (STARVE_LIMIT > 0) ? $clog2(STARVE_LIMIT + 1) : 1;
  localparam logic [CntW-1:0] CntMax = CntW'(STARVE_LIMIT);

  logic [CntW-1:0]    starve_cnt [NUM_REQ];
  logic [NUM_REQ-1:0] urgent;
  logic [NUM_REQ-1:0] granted;
  port_t              port_sel [NUM_REQ];

  logic [IdxW-1:0] first_idx, second_idx;
  logic            first_vld, second_vld, second_ok;
  logic [ADDR_WIDTH-1:0] first_addr, second_addr, a_addr, b_addr;
  logic [DATA_WIDTH-1:0] first_wdata, second_wdata, a_wdata, b_wdata, q_a, q_b;
  logic            first_we, second_we, a_we, b_we;

  always_comb begin
    for (int i = 0; i < NUM_REQ; i++) begin
      urgent[i] = (STARVE_LIMIT != 0) && (starve_cnt[i] == CntMax);
    end
  end

  mem_arb_rank #(
    .NUM_REQ (NUM_REQ),
    .IDX_W   (IdxW)
  ) u_rank (
    .active     (req_en),
    .urgent     (urgent),
    .first_idx  (first_idx),
    .first_vld  (first_vld),
    .second_idx (second_idx),
    .second_vld (second_vld)
  );

  assign first_addr   = ADDR_WIDTH'(get_slice(MaxVecW'(req_addr), 32'(first_idx), ADDR_WIDTH));
  assign second_addr  = ADDR_WIDTH'(get_slice(MaxVecW'(req_addr), 32'(second_idx), ADDR_WIDTH));
  assign first_wdata  = DATA_WIDTH'(get_slice(MaxVecW'(req_wdata), 32'(first_idx), DATA_WIDTH));
  assign second_wdata = DATA_WIDTH'(get_slice(MaxVecW'(req_wdata), 32'(second_idx), DATA_WIDTH));
  assign first_we     = req_we[first_idx];
  assign second_we    = req_we[second_idx];

  // A blocked second candidate leaves port B idle; nobody else is promoted.
  assign second_ok = second_vld && !((first_addr == second_addr) && (first_we || second_we));

  always_comb begin
    req_ready = '0;
    if (rst_n) begin
      if (first_vld) req_ready[first_idx] = 1'b1;
      if (second_ok) req_ready[second_idx] = 1'b1;
    end
  end

  assign a_we    = first_vld && first_we && rst_n;
  assign a_addr  = first_vld ? first_addr : '0;
  assign a_wdata = first_vld ? first_wdata : '0;
  assign b_we    = second_ok && second_we && rst_n;
  assign b_addr  = second_ok ? second_addr : '0;
  assign b_wdata = second_ok ? second_wdata : '0;

  memory_map #(
    .DATA_WIDTH (DATA_WIDTH),
    .ADDR_WIDTH (ADDR_WIDTH),
    .MEM_AW     (DefMemAw)
  ) u_mem (
    .clk     (clk),
    .we_a    (a_we),
    .addr_a  (a_addr),
    .wdata_a (a_wdata),
    .q_a     (q_a),
    .we_b    (b_we),
    .addr_b  (b_addr),
    .wdata_b (b_wdata),
    .q_b     (q_b)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      granted <= '0;
      for (int i = 0; i < NUM_REQ; i++) begin
        starve_cnt[i] <= '0;
        port_sel[i]   <= PORT_A;
      end
    end else begin
      granted <= req_en & req_ready;
      for (int i = 0; i < NUM_REQ; i++) begin
        if (!req_en[i] || req_ready[i]) begin
          starve_cnt[i] <= '0;
        end else if (starve_cnt[i] != CntMax) begin
          starve_cnt[i] <= starve_cnt[i] + 1'b1;
        end
        port_sel[i] <= (second_ok && (second_idx == IdxW'(i))) ? PORT_B : PORT_A;
      end
    end
  end

  assign rsp_valid = granted;

  always_comb begin
    rsp_rdata = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (granted[i]) rsp_rdata[i*DATA_WIDTH +: DATA_WIDTH] = (port_sel[i] == PORT_B) ? q_b : q_a;
    end
  end

endmodule

// File: tb/tb_mem_arbiter_nport.sv
// Directed and randomized checks of mem_arbiter_nport against a queue-based ranking model.
module tb_mem_arbiter_nport;

  localparam int NR = 3;
  localparam int DW = 32;
  localparam int AW = 32;
  localparam int L  = 2;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic [NR-1:0]    req_en = '0, req_we = '0, req_ready, rsp_valid;
  logic [NR*AW-1:0] req_addr = '0;
  logic [NR*DW-1:0] req_wdata = '0, rsp_rdata;

  always #5 clk = ~clk;

  mem_arbiter_nport #(
    .DATA_WIDTH   (DW),
    .ADDR_WIDTH   (AW),
    .NUM_REQ      (NR),
    .STARVE_LIMIT (L)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_en    (req_en),
    .req_we    (req_we),
    .req_addr  (req_addr),
    .req_wdata (req_wdata),
    .req_ready (req_ready),
    .rsp_valid (rsp_valid),
    .rsp_rdata (rsp_rdata)
  );

  int n_tests = 0;
  int n_fail  = 0;

  int            m_starve [NR];
  logic [DW-1:0] m_mem [logic [AW-1:0]];
  logic [NR-1:0] exp_vld = '0;
  logic [DW-1:0] exp_data [NR];
  bit            exp_known [NR];
  logic [NR-1:0] got_ready, got_vld, last_g = '0;
  logic [DW-1:0] got_data [NR];

  task automatic check(string tag, logic [63:0] got, logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [AW-1:0] addr_of(int i);
    return req_addr[i*AW +: AW];
  endfunction

  function automatic bit is_urgent(int i);
    return (L != 0) && (m_starve[i] == L);
  endfunction

  // Rank urgent requesters first, then the rest, each group in index order; take the top two.
  function automatic logic [NR-1:0] model_ready();
    int order[$];
    logic [NR-1:0] r;
    r = '0;
    if (!rst_n) return r;
    for (int i = 0; i < NR; i++) if (req_en[i] && is_urgent(i)) order.push_back(i);
    for (int i = 0; i < NR; i++) if (req_en[i] && !is_urgent(i)) order.push_back(i);
    if (order.size() > 0) r[order[0]] = 1'b1;
    if (order.size() > 1) begin
      if (!((addr_of(order[0]) == addr_of(order[1])) && (req_we[order[0]] || req_we[order[1]])))
        r[order[1]] = 1'b1;
    end
    return r;
  endfunction

  task automatic set_req(int i, bit en, bit we, logic [AW-1:0] a, logic [DW-1:0] d);
    req_en[i] = en;
    req_we[i] = we;
    req_addr[i*AW +: AW] = a;
    req_wdata[i*DW +: DW] = d;
  endtask

  task automatic step();
    logic [NR-1:0] er;
    logic [NR-1:0] g;
    #2;
    er = model_ready();
    got_ready = req_ready;
    check("req_ready", 64'(got_ready), 64'(er));
    g = er & req_en;
    @(posedge clk);
    if (!rst_n) begin
      exp_vld = '0;
      g = '0;
      for (int i = 0; i < NR; i++) m_starve[i] = 0;
    end else begin
      for (int i = 0; i < NR; i++) begin
        exp_vld[i] = g[i];
        exp_known[i] = 1'b0;
        if (g[i] && !req_we[i] && m_mem.exists(addr_of(i))) begin
          exp_known[i] = 1'b1;
          exp_data[i] = m_mem[addr_of(i)];
        end
      end
      for (int i = 0; i < NR; i++) if (g[i] && req_we[i]) m_mem[addr_of(i)] = req_wdata[i*DW +: DW];
      for (int i = 0; i < NR; i++) begin
        if (!req_en[i] || g[i]) m_starve[i] = 0;
        else if (m_starve[i] < L) m_starve[i]++;
      end
    end
    last_g = g;
    #1;
    got_vld = rsp_valid;
    check("rsp_valid", 64'(got_vld), 64'(exp_vld));
    for (int i = 0; i < NR; i++) begin
      got_data[i] = rsp_rdata[i*DW +: DW];
      if (!exp_vld[i]) check("rsp_rdata_idle", 64'(got_data[i]), 64'd0);
      else if (exp_known[i]) check("rsp_rdata", 64'(got_data[i]), 64'(exp_data[i]));
    end
  endtask

  // Protocol monitor: a pending, not-ready request must be held unchanged.
  logic [NR-1:0]    p_en = '0, p_we = '0, p_ready = '0;
  logic [NR*AW-1:0] p_addr = '0;
  logic [NR*DW-1:0] p_wdata = '0;
  logic             p_rst = 1'b0;
  always @(posedge clk) begin
    for (int i = 0; i < NR; i++) begin
      if (p_rst && rst_n && p_en[i] && !p_ready[i]) begin
        assert (req_en[i] && (req_we[i] == p_we[i]) && (req_addr[i*AW +: AW] == p_addr[i*AW +: AW])
                && (req_wdata[i*DW +: DW] == p_wdata[i*DW +: DW]))
          else $error("FAIL hold rule requester %0d", i);
      end
    end
    p_en    <= req_en;
    p_we    <= req_we;
    p_ready <= req_ready;
    p_addr  <= req_addr;
    p_wdata <= req_wdata;
    p_rst   <= rst_n;
  end

  initial begin
    for (int i = 0; i < NR; i++) begin
      m_starve[i] = 0;
      exp_known[i] = 1'b0;
      exp_data[i] = '0;
    end

    // Reset with everyone requesting, then contention and aging of requester 2.
    rst_n = 1'b0;
    for (int i = 0; i < NR; i++) set_req(i, 1'b1, 1'b0, AW'(i), '0);
    repeat (2) begin
      step();
      check("rst_ready", 64'(got_ready), 64'd0);
      check("rst_rsp_valid", 64'(got_vld), 64'd0);
      for (int i = 0; i < NR; i++) check("rst_rsp_rdata", 64'(got_data[i]), 64'd0);
    end
    rst_n = 1'b1;
    step();
    check("cont_c0_ready", 64'(got_ready), 64'b011);
    check("cont_c0_rsp", 64'(got_vld), 64'b011);
    set_req(0, 1'b1, 1'b0, 32'h3, '0);
    set_req(1, 1'b1, 1'b0, 32'h4, '0);
    step();
    check("starve_c1_ready", 64'(got_ready), 64'b011);
    set_req(0, 1'b1, 1'b0, 32'h5, '0);
    set_req(1, 1'b1, 1'b0, 32'h6, '0);
    step();
    check("starve_c2_ready", 64'(got_ready), 64'b101);
    set_req(0, 1'b0, 1'b0, '0, '0);
    set_req(2, 1'b0, 1'b0, '0, '0);
    step();
    check("starve_held_ready", 64'(got_ready), 64'b010);
    set_req(1, 1'b0, 1'b0, '0, '0);

    // Write then read back through requester 2 alone.
    set_req(2, 1'b1, 1'b1, 32'h10, 32'hDEADBEEF);
    step();
    check("wr_ready", 64'(got_ready), 64'b100);
    check("wr_rsp", 64'(got_vld), 64'b100);
    set_req(2, 1'b1, 1'b0, 32'h10, '0);
    step();
    check("rd_ready", 64'(got_ready), 64'b100);
    check("rd_data", 64'(got_data[2]), 64'hDEADBEEF);
    set_req(2, 1'b0, 1'b0, '0, '0);

    // Same-address hazard: only the write goes, the read follows next cycle.
    set_req(0, 1'b1, 1'b1, 32'h20, 32'hA5A50F0F);
    set_req(1, 1'b1, 1'b0, 32'h20, '0);
    step();
    check("hz_ready", 64'(got_ready), 64'b001);
    set_req(0, 1'b0, 1'b0, '0, '0);
    step();
    check("hz_ready2", 64'(got_ready), 64'b010);
    check("hz_data", 64'(got_data[1]), 64'hA5A50F0F);
    set_req(1, 1'b0, 1'b0, '0, '0);

    // Reset coinciding with a write must suppress both the write and the response.
    set_req(0, 1'b1, 1'b1, 32'h30, 32'h11);
    step();
    set_req(0, 1'b1, 1'b1, 32'h30, 32'h55);
    rst_n = 1'b0;
    step();
    check("mid_rst_rsp", 64'(got_vld), 64'd0);
    rst_n = 1'b1;
    set_req(0, 1'b1, 1'b0, 32'h30, '0);
    step();
    check("mid_rst_data", 64'(got_data[0]), 64'h11);
    set_req(0, 1'b0, 1'b0, '0, '0);
    step();

    // Random traffic on a small address window so hazards and aging happen often.
    for (int c = 0; c < 600; c++) begin
      rst_n = ($urandom_range(0, 79) != 0);
      for (int i = 0; i < NR; i++) begin
        if (!(req_en[i] && !last_g[i])) begin
          set_req(i, $urandom_range(0, 3) != 0, $urandom_range(0, 2) == 0,
                  AW'($urandom_range(0, 7)), DW'($urandom));
        end
      end
      step();
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/mem_arbiter_nport.md
# mem_arbiter_nport

Parametrised N-requester arbiter in front of the dual-port `memory_map` SRAM. It is the successor to the fixed CPU/accelerator/DMA memory controller. Up to two requests are granted per cycle, one per memory port. Ranking is fixed priority with starvation aging, and losers are back-pressured through a ready handshake instead of being silently buffered. Every granted access, read or write, returns exactly one response pulse one cycle later.

## Interface
Parameters:
- `DATA_WIDTH`, 32, data word width
- `ADDR_WIDTH`, 32, address width passed to `memory_map`
- `NUM_REQ`, 3, number of requesters (≥2); index 0 is highest static priority
- `STARVE_LIMIT`, 4, consecutive denied cycles before a requester becomes urgent; 0 disables aging

Ports:
- `clk`  in  1  single clock; all state on rising edge
- `rst_n`  in  1  reset, synchronous and active-low
- `req_en`  in  NUM_REQ  request valid per requester
- `req_we`  in  NUM_REQ  1 = write, 0 = read
- `req_addr`  in  NUM_REQ*ADDR_WIDTH  packed addresses; requester i in slice [i*ADDR_WIDTH +: ADDR_WIDTH]
- `req_wdata`  in  NUM_REQ*DATA_WIDTH  packed write data, same packing
- `req_ready`  out  NUM_REQ  combinational grant; the access is taken this cycle when `req_en[i] & req_ready[i]`
- `rsp_valid`  out  NUM_REQ  registered one-cycle pulse, one per granted access
- `rsp_rdata`  out  NUM_REQ*DATA_WIDTH  read data; zero whenever the matching `rsp_valid` is low

## Operation
- **Request hold rule.** The requester holds `req_en`, `req_we`, `req_addr` and `req_wdata` stable until `req_ready` is seen high. Changing them while not ready is a protocol violation, flagged by a bench assertion.
- **Ranking.** Urgent requesters rank above non-urgent ones. Within each class, the lower index wins.
- **Urgent.** A requester is urgent when `starve_cnt[i] == STARVE_LIMIT` and `STARVE_LIMIT != 0`.
- **Port assignment.** The first-ranked active requester gets port A. The second-ranked gets port B, subject to the hazard rule below. At most two grants are made per cycle.
- **Hazard rule.** If the second candidate has the same address as the first and either access is a write, the second is not granted that cycle. No third candidate is promoted into its place.
- **No port on a grant.** A port with no grant drives write enable 0, with address and data 0.
- **Starvation counter per requester.** Width $clog2(STARVE_LIMIT+1). It clears when `req_en[i]` is low or the requester is granted. It increments when `req_en[i] & ~req_ready[i]` and saturates at STARVE_LIMIT.
- **Response tracking.** Per requester, register `granted[i]` and `port_sel[i]` (A/B). Next cycle, `rsp_valid[i] = granted[i]` and `rsp_rdata[i]` = q of the selected port. For writes, `rsp_rdata` carries the port's q and is don't-care to the consumer.
- **Back-to-back requests.** A requester may issue a new request in the cycle after its grant. Responses never overlap, because there is at most one grant per requester per cycle.

## Timing
- Arbitration is combinational within the request cycle. `req_ready` depends on `req_en`, `req_we`, `req_addr` and the starve state only; it has no path from `rsp_*`.
- Latency from grant to `rsp_valid` is exactly 1 cycle, with read data taken from `memory_map` registered q.
- **Reset behaviour.** While `rst_n` is low at a clock edge:
  - all starve counters, `granted` and `port_sel` go to 0;
  - in the following cycle `rsp_valid` = 0 and `rsp_rdata` = 0;
  - `req_ready` is forced to 0 while `rst_n` is low.
- **Reset mid-operation.** A grant made in the cycle where reset is sampled produces no response. The memory write for that grant is suppressed, because `we` is gated by `rst_n`.
- **Single requester.** The requester is always granted port A in the same cycle; starvation never grows.
- **All NUM_REQ active with no hazards.** Exactly two grants per cycle. With STARVE_LIMIT=L, any requester waits at most L+⌈NUM_REQ/2⌉ cycles.
- **Two urgent requesters.** Both are ranked by index; an urgent requester with the lowest index always gets port A.

## Structure
- **Package `mem_arb_pkg`:**
  - `typedef enum logic {PORT_A, PORT_B} port_t`
  - `localparam` default widths
  - a `function` to extract a packed slice by index
- **Sub-module `mem_arb_rank`:**
  - combinational top-two picker;
  - inputs: active vector, urgent vector;
  - outputs: `first_idx`, `first_vld`, `second_idx`, `second_vld`.
- **Top level:** instantiates `mem_arb_rank` and `memory_map`, and owns the starve counters, hazard check and response registers.

## Test plan
- **Reset.** Hold `rst_n`=0 for 2 cycles with all `req_en`=1 -> `req_ready`=0, `rsp_valid`=0, `rsp_rdata`=0. Release reset -> first grants go to requesters 0 and 1.
- **Write/read-back.** Requester 2 alone writes 0xDEADBEEF to addr 0x10, then reads 0x10 -> each `req_ready[2]` is high in its request cycle, and `rsp_valid[2]` pulses the next cycle. The read response carries `rsp_rdata[2]`=0xDEADBEEF.
- **Three-way contention.** All three issue reads to distinct addresses -> cycle 0 grants 0 (port A) and 1 (port B), with 2 held. Requester 2 is granted once 0 and 1 drop or it becomes urgent.
- **Starvation.** STARVE_LIMIT=2; requesters 0 and 1 request continuously and requester 2 holds its request -> `req_ready[2]` rises in the 3rd cycle of waiting. Requester 1 is denied in that cycle.
- **Address hazard.** Requester 0 writes addr 0x20 while requester 1 reads 0x20 in the same cycle -> only requester 0 is granted. The next cycle, requester 1 reads back requester 0's data.
- **Reset mid-operation.** Assert `rst_n`=0 in the same cycle as a granted write of 0x55 to addr 0x30 -> no `rsp_valid` follows, and a later read of 0x30 does not return 0x55.
